// File: rtl/rot_out_framer.sv
// Output framer for the rotation buffer read path: tags pixels with SOF/EOL,
// queues them in a first-word-fall-through FIFO and tracks line geometry.
module rot_out_framer #(
    parameter int DEPTH       = 16,
    parameter int FRAME_LINES = 256,
    parameter int MAX_W       = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [23:0] pix_in,
    input  logic        eol_in,
    output logic [23:0] out_data,
    output logic        out_sof,
    output logic        out_eol,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [8:0]  line_width,
    output logic [8:0]  line_count,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow,
    output logic        long_line
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [8:0]    COL_LAST  = 9'(MAX_W - 1);
    localparam logic [8:0]    LINES_END = 9'(FRAME_LINES);
    localparam logic [AW:0]   OCC_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   OCC_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [25:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic [8:0]    col_q, col_d, lw_q, lw_d, lc_q, lc_d;
    logic          sof_pend_q, sof_pend_d;
    logic          busy_q, busy_d, fd_q, fd_d, ovf_q, ovf_d, long_q, long_d;
    logic          pop_s, push_req_s, push_acc_s, eol_s;
    logic [25:0]   entry_s;

    assign out_valid  = |occ_q;
    assign {out_sof, out_eol, out_data} = out_valid ? mem_q[rd_ptr_q] : 26'd0;
    assign line_width = lw_q;
    assign line_count = lc_q;
    assign busy       = busy_q;
    assign frame_done = fd_q;
    assign overflow   = ovf_q;
    assign long_line  = long_q;

    // Next-state: framing FSM, geometry counters and FIFO bookkeeping.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        col_d      = col_q;
        lw_d       = lw_q;
        lc_d       = lc_q;
        sof_pend_d = sof_pend_q;
        ovf_d      = ovf_q;
        long_d     = long_q;
        fd_d       = 1'b0;
        push_req_s = 1'b0;
        pop_s      = out_valid & out_ready;
        eol_s      = eol_in | (col_q == COL_LAST);
        entry_s    = {sof_pend_q, eol_s, pix_in};

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d    = S_RUN;
                    col_d      = 9'd0;
                    lc_d       = 9'd0;
                    ovf_d      = 1'b0;
                    long_d     = 1'b0;
                    sof_pend_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    state_d = S_DRAIN;
                end else begin
                    push_req_s = 1'b1;
                    sof_pend_d = 1'b0;
                    if (!eol_in && (col_q == COL_LAST)) begin
                        long_d = 1'b1;
                    end else begin
                        long_d = long_q;
                    end
                    // Geometry advances even when the pixel is dropped.
                    if (eol_s) begin
                        col_d = 9'd0;
                        lw_d  = col_q + 9'd1;
                        lc_d  = lc_q + 9'd1;
                        if ((lc_q + 9'd1) == LINES_END) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_RUN;
                        end
                    end else begin
                        col_d = col_q + 9'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (!out_valid) begin
                    state_d = S_DONE;
                    fd_d    = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        push_acc_s = push_req_s & ((occ_q != OCC_FULL) | pop_s);
        if (push_req_s && !push_acc_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_d;
        end
        if (push_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_acc_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
        busy_d = (state_d == S_RUN) | (state_d == S_DRAIN);
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            col_q      <= 9'd0;
            lw_q       <= 9'd0;
            lc_q       <= 9'd0;
            sof_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            fd_q       <= 1'b0;
            ovf_q      <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            col_q      <= col_d;
            lw_q       <= lw_d;
            lc_q       <= lc_d;
            sof_pend_q <= sof_pend_d;
            busy_q     <= busy_d;
            fd_q       <= fd_d;
            ovf_q      <= ovf_d;
            long_q     <= long_d;
        end
    end

    // FIFO storage; contents are only observed through the valid-gated head.
    always_ff @(posedge clk) begin
        if (push_acc_s) begin
            mem_q[wr_ptr_q] <= entry_s;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end
endmodule

// File: tb/tb_rot_out_framer.sv
// Randomized scoreboard bench for rot_out_framer with a queue-based reference model.
module tb_rot_out_framer;
    localparam int DEPTH = 16, FRAME_LINES = 4, MAX_W = 256;
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, eol_in = 1'b0, out_ready = 1'b0;
    logic [23:0] pix_in = 24'd0;
    logic [23:0] out_data;
    logic        out_sof, out_eol, out_valid, busy, frame_done, overflow, long_line;
    logic [8:0]  line_width, line_count;

    rot_out_framer #(.DEPTH(DEPTH), .FRAME_LINES(FRAME_LINES), .MAX_W(MAX_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pix_in(pix_in), .eol_in(eol_in),
        .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol), .out_valid(out_valid),
        .out_ready(out_ready), .line_width(line_width), .line_count(line_count),
        .busy(busy), .frame_done(frame_done), .overflow(overflow), .long_line(long_line)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, n_pop = 0, fd_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame phase, geometry and an expected-output queue.
    int          m_phase = 0, m_col = 0, m_lines = 0, m_lw = 0, m_occ = 0;
    bit          m_sofp = 0, m_ovf = 0, m_long = 0, m_fd = 0;
    bit          m_pop, m_eol, m_acc;
    logic [25:0] sb[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = P_IDLE; m_col = 0; m_lines = 0; m_lw = 0; m_occ = 0;
            m_sofp = 0; m_ovf = 0; m_long = 0; m_fd = 0;
            sb.delete();
        end else begin
            m_pop = (m_occ > 0) && out_ready;
            m_acc = 0;
            m_fd  = 0;
            case (m_phase)
                P_IDLE: if (enable) begin
                    m_phase = P_RUN; m_col = 0; m_lines = 0;
                    m_ovf = 0; m_long = 0; m_sofp = 1;
                end
                P_RUN: if (!enable) m_phase = P_DRAIN;
                else begin
                    m_eol = eol_in || (m_col == MAX_W - 1);
                    if (!eol_in && m_col == MAX_W - 1) m_long = 1;
                    m_acc = (m_occ < DEPTH) || m_pop;
                    if (m_acc) sb.push_back({m_sofp, m_eol, pix_in});
                    else m_ovf = 1;
                    m_sofp = 0;
                    if (m_eol) begin
                        m_lw = m_col + 1;
                        m_col = 0;
                        m_lines++;
                        if (m_lines == FRAME_LINES) m_phase = P_DRAIN;
                    end else m_col++;
                end
                P_DRAIN: if (m_occ == 0) begin m_phase = P_DONE; m_fd = 1; end
                default: if (!enable) m_phase = P_IDLE;
            endcase
            m_occ = m_occ + (m_acc ? 1 : 0) - (m_pop ? 1 : 0);
        end
    end

    // Monitor: compare status every cycle and the head against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", out_valid, m_occ > 0);
            chk("busy", busy, (m_phase == P_RUN) || (m_phase == P_DRAIN));
            chk("frame_done", frame_done, m_fd);
            chk("line_width", line_width, m_lw);
            chk("line_count", line_count, m_lines);
            chk("overflow", overflow, m_ovf);
            chk("long_line", long_line, m_long);
            if (frame_done) fd_seen++;
            if (out_valid) begin
                chk("head_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    chk("head", {out_sof, out_eol, out_data}, sb[0]);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        n_pop++;
                    end
                end
            end
        end
    end

    task automatic drive(input bit en, input logic [23:0] px, input bit eol, input bit rdy);
        enable = en; pix_in = px; eol_in = eol; out_ready = rdy;
        @(posedge clk); #1;
    endtask

    task automatic to_idle();
        int n = 0;
        while ((m_phase != P_IDLE || m_occ != 0) && n < 300) begin
            drive(0, 24'($urandom), 1'($urandom), 1);
            n++;
        end
        drive(0, 24'd0, 0, 1);
        chk("to_idle_timeout", n < 300, 1);
    endtask

    int p0, f0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) drive(0, 24'd0, 0, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lc", line_count, 0);
        rst_n = 1'b1;
        drive(0, 24'd0, 0, 0);

        // Normal frame: 4 lines of 8 pixels, consumer always ready.
        p0 = n_pop; f0 = fd_seen;
        drive(1, 24'($urandom), 1, 1);
        for (int i = 0; i < 32; i++) drive(1, 24'($urandom), (i % 8) == 7, 1);
        for (int i = 0; i < 40 && m_phase != P_DONE; i++) drive(1, 24'($urandom), 0, 1);
        repeat (2) drive(1, 24'($urandom), 0, 1);
        chk("t1_lw", line_width, 8);
        chk("t1_lc", line_count, 4);
        chk("t1_ovf", overflow, 0);
        chk("t1_pixels", n_pop - p0, 32);
        chk("t1_fd_pulses", fd_seen - f0, 1);
        chk("t1_busy_done", busy, 0);
        to_idle();

        // Backpressure: 20 pushes into a 16-deep FIFO.
        p0 = n_pop;
        drive(1, 24'd0, 0, 0);
        for (int i = 0; i < 20; i++) drive(1, 24'($urandom), (i % 8) == 7, 0);
        chk("t2_ovf", overflow, 1);
        chk("t2_lc", line_count, 2);
        to_idle();
        chk("t2_pixels", n_pop - p0, 16);

        // Full FIFO with simultaneous pop must not drop.
        p0 = n_pop;
        drive(1, 24'd0, 0, 0);
        for (int i = 0; i < 16; i++) drive(1, 24'($urandom), (i % 8) == 7, 0);
        for (int i = 16; i < 24; i++) drive(1, 24'($urandom), (i % 8) == 7, 1);
        chk("t3_ovf_none", overflow, 0);
        drive(1, 24'($urandom), 0, 0);
        chk("t3_ovf_full", overflow, 1);
        to_idle();
        chk("t3_pixels", n_pop - p0, 24);

        // Long line: forced eol at pixel 256, next line restarts at col 0.
        drive(1, 24'd0, 0, 1);
        for (int i = 0; i < 300; i++) drive(1, 24'($urandom), 0, 1);
        chk("t4_long", long_line, 1);
        chk("t4_lw", line_width, 256);
        chk("t4_lc", line_count, 1);
        drive(1, 24'($urandom), 1, 1);
        chk("t4_lw_next", line_width, 45);
        chk("t4_lc_next", line_count, 2);
        to_idle();

        // Abort after 5 pixels.
        p0 = n_pop; f0 = fd_seen;
        drive(1, 24'd0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 24'($urandom), 0, 0);
        drive(0, 24'd0, 0, 0);
        chk("t5_busy_drain", busy, 1);
        to_idle();
        chk("t5_pixels", n_pop - p0, 5);
        chk("t5_fd_pulses", fd_seen - f0, 1);

        // Reset with 3 pixels queued.
        drive(1, 24'd0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 24'($urandom), i == 2, 0);
        chk("t6_lc_before", line_count, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_data", {out_sof, out_eol, out_data}, 0);
        chk("t6_geom", {line_width, line_count}, 0);
        chk("t6_flags", {busy, frame_done, overflow, long_line}, 0);
        drive(0, 24'd0, 0, 0);
        rst_n = 1'b1;
        drive(0, 24'd0, 0, 0);
        chk("t6_idle_busy", busy, 0);

        // Stall hold: random out_ready with sequential pixel values.
        drive(1, 24'd0, 0, 0);
        for (int i = 0; i < 40; i++)
            drive(1, 24'(i), $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 20; i++)
            drive(1, 24'($urandom), 0, 1'($urandom_range(0, 1)));
        to_idle();

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
